arith_mult_pipe_multi_side: RTL and testbench

//  NB_CH-lane pipelined multiplier z[i] = a[i]*b[i] with side data and valid/ready backpressure.

---
 rtl/arith_mult_pipe_multi_side.sv | 205 ++++++++++++++++++++
 tb/tb_arith_mult_pipe_multi_side.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_mult_pipe_multi_side.sv
// NB_CH-lane pipelined multiplier with per-lane mask, side data and a credit-controlled skid FIFO.
// Define ARITH_MULT_PIPE_SIGNED_EN for two's-complement operands; the default build is unsigned.
module arith_mult_pipe_multi_side #(
   parameter  int OP_A_W   = 16,
   parameter  int OP_B_W   = 16,
   parameter  int NB_CH    = 4,
   parameter  int MULT_LAT = 3,
   parameter  int SIDE_W   = 0,
   parameter  int RST_SIDE = 0,
   localparam int DEPTH    = MULT_LAT + 2,
   localparam int Z_W      = OP_A_W + OP_B_W,
   localparam int SW       = (SIDE_W > 0) ? SIDE_W : 1,
   localparam int OCC_W    = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    s_rst_n,
   input  logic [NB_CH*OP_A_W-1:0] in_a,
   input  logic [NB_CH*OP_B_W-1:0] in_b,
   input  logic [NB_CH-1:0]        in_mask,
   input  logic [SW-1:0]           in_side,
   input  logic                    in_vld,
   output logic                    in_rdy,
   output logic [NB_CH*Z_W-1:0]    out_z,
   output logic [SW-1:0]           out_side,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [OCC_W-1:0]        occ
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [SW-1:0] SIDE_RST = ((RST_SIDE & 1) != 0) ? '0 : '1;

   logic                    accept;
   logic                    pop;
   logic                    wr_en;
   logic [NB_CH*Z_W-1:0]    wr_data;

   logic                    rst_done_q;
   logic [OCC_W-1:0]        occ_q, occ_d;
   logic [OCC_W-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;

   logic [NB_CH*OP_A_W-1:0] a0_q;
   logic [NB_CH*OP_B_W-1:0] b0_q;
   logic [NB_CH-1:0]        m0_q;
   logic [NB_CH*Z_W-1:0]    prod_c;

   logic                    vld_q  [MULT_LAT];
   logic [SW-1:0]           side_q [MULT_LAT];

   logic [NB_CH*Z_W-1:0]    mem_z_q [DEPTH];
   logic [SW-1:0]           mem_s_q [DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake: a beat moves on a cycle where valid and ready are both high at the clock edge;
   // in_rdy depends only on the credit count, never on in_vld, and out_vld never waits on out_rdy.
   assign in_rdy  = rst_done_q & (occ_q < OCC_W'(DEPTH));
   assign accept  = in_vld & in_rdy;
   assign out_vld = (cnt_q != '0);
   assign pop     = out_vld & out_rdy;
   assign occ     = occ_q;
   assign wr_en   = vld_q[MULT_LAT-1];

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         rst_done_q <= 1'b0;
      end else begin
         rst_done_q <= 1'b1;
      end
   end

   // Operand capture; data is never reset, the valid pipe alone qualifies it.
   always_ff @(posedge clk) begin
      a0_q <= in_a;
      b0_q <= in_b;
      m0_q <= in_mask;
   end

   always_comb begin
      prod_c = '0;
      for (int i = 0; i < NB_CH; i++) begin
         if (m0_q[i]) begin
`ifdef ARITH_MULT_PIPE_SIGNED_EN
            prod_c[i*Z_W +: Z_W] =
               {{OP_B_W{a0_q[i*OP_A_W+OP_A_W-1]}}, a0_q[i*OP_A_W +: OP_A_W]} *
               {{OP_A_W{b0_q[i*OP_B_W+OP_B_W-1]}}, b0_q[i*OP_B_W +: OP_B_W]};
`else
            prod_c[i*Z_W +: Z_W] =
               {{OP_B_W{1'b0}}, a0_q[i*OP_A_W +: OP_A_W]} *
               {{OP_A_W{1'b0}}, b0_q[i*OP_B_W +: OP_B_W]};
`endif
         end
      end
   end

   // The FIFO write counts as the last of the MULT_LAT stages, giving MULT_LAT+1 cycles end to end.
   generate
      if (MULT_LAT == 1) begin : g_lat1
         assign wr_data = prod_c;
      end else begin : g_latn
         logic [NB_CH*Z_W-1:0] dp_q [1:MULT_LAT-1];
         always_ff @(posedge clk) begin
            dp_q[1] <= prod_c;
            for (int k = 2; k < MULT_LAT; k++) begin
               dp_q[k] <= dp_q[k-1];
            end
         end
         assign wr_data = dp_q[MULT_LAT-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         for (int k = 0; k < MULT_LAT; k++) begin
            vld_q[k] <= 1'b0;
         end
      end else begin
         vld_q[0] <= accept;
         for (int k = 1; k < MULT_LAT; k++) begin
            vld_q[k] <= vld_q[k-1];
         end
      end
   end

   generate
      if (RST_SIDE != 0) begin : g_side_rst
         always_ff @(posedge clk or negedge s_rst_n) begin
            if (!s_rst_n) begin
               for (int k = 0; k < MULT_LAT; k++) begin
                  side_q[k] <= SIDE_RST;
               end
            end else begin
               side_q[0] <= in_side;
               for (int k = 1; k < MULT_LAT; k++) begin
                  side_q[k] <= side_q[k-1];
               end
            end
         end
      end else begin : g_side_nrst
         always_ff @(posedge clk) begin
            side_q[0] <= in_side;
            for (int k = 1; k < MULT_LAT; k++) begin
               side_q[k] <= side_q[k-1];
            end
         end
      end
   endgenerate

   always_comb begin
      occ_d    = occ_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (accept && !pop) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!accept && pop) begin
         occ_d = occ_q - OCC_W'(1);
      end
      if (wr_en && !pop) begin
         cnt_d = cnt_q + OCC_W'(1);
      end else if (!wr_en && pop) begin
         cnt_d = cnt_q - OCC_W'(1);
      end
      if (wr_en) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         occ_q    <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         // Credits bound everything in flight, so a write can never land on a full FIFO.
         if (wr_en) begin
            assert (cnt_q < OCC_W'(DEPTH));
         end
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_z_q[wr_ptr_q] <= wr_data;
         mem_s_q[wr_ptr_q] <= side_q[MULT_LAT-1];
      end
   end

   // Head slot is never the write target while occupied, so outputs hold through a stall.
   assign out_z    = out_vld ? mem_z_q[rd_ptr_q] : '0;
   assign out_side = ((SIDE_W > 0) && out_vld) ? mem_s_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_arith_mult_pipe_multi_side.sv
// Directed bench for arith_mult_pipe_multi_side: NB_CH=4, 16x16 operands, MULT_LAT=3, SIDE_W=8.
module tb_arith_mult_pipe_multi_side;

   localparam int MULT_LAT = 3;
   localparam int DEPTH    = MULT_LAT + 2;

   logic         clk;
   logic         s_rst_n;
   logic [63:0]  in_a;
   logic [63:0]  in_b;
   logic [3:0]   in_mask;
   logic [7:0]   in_side;
   logic         in_vld;
   logic         in_rdy;
   logic [127:0] out_z;
   logic [7:0]   out_side;
   logic         out_vld;
   logic         out_rdy;
   logic [2:0]   occ;

   int total = 0;
   int bad   = 0;
   int pop_cnt = 0;
   int occ_m = 0;
   logic [135:0] exp_q[$];
   logic [135:0] exp_e;

   arith_mult_pipe_multi_side #(
      .OP_A_W(16), .OP_B_W(16), .NB_CH(4), .MULT_LAT(MULT_LAT), .SIDE_W(8), .RST_SIDE(1)
   ) dut (
      .clk(clk), .s_rst_n(s_rst_n), .in_a(in_a), .in_b(in_b), .in_mask(in_mask),
      .in_side(in_side), .in_vld(in_vld), .in_rdy(in_rdy), .out_z(out_z),
      .out_side(out_side), .out_vld(out_vld), .out_rdy(out_rdy), .occ(occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] lane_prod(input logic [15:0] a, input logic [15:0] b);
`ifdef ARITH_MULT_PIPE_SIGNED_EN
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      return 32'(sa * sb);
`else
      longint ua, ub;
      ua = longint'(a);
      ub = longint'(b);
      return 32'(ua * ub);
`endif
   endfunction

   function automatic logic [127:0] model_z(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] m);
      logic [127:0] z;
      z = '0;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) z[i*32 +: 32] = lane_prod(a[i*16 +: 16], b[i*16 +: 16]);
      end
      return z;
   endfunction

   // Scoreboard: values seen at the edge are the pre-edge ones.
   always @(posedge clk) begin
      if (!s_rst_n) begin
         exp_q.delete();
         occ_m = 0;
      end else begin
         total++;
         if (occ !== 3'(occ_m)) begin
            bad++;
            $display("FAIL sb_occ got=%0d want=%0d", occ, occ_m);
         end
         if (out_vld && out_rdy) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected_pop got z=%h side=%h want=no beat", out_z, out_side);
            end else begin
               exp_e = exp_q.pop_front();
               if ({out_side, out_z} !== exp_e) begin
                  bad++;
                  $display("FAIL sb_beat got=%h want=%h", {out_side, out_z}, exp_e);
               end
            end
            pop_cnt++;
            occ_m--;
         end
         if (in_vld && in_rdy) begin
            exp_q.push_back({in_side, model_z(in_a, in_b, in_mask)});
            occ_m++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      s_rst_n = 1'b0;
      in_vld = 1'b0; out_rdy = 1'b0;
      in_a = '0; in_b = '0; in_mask = '0; in_side = '0;
      #12;
      total++;
      if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld got=%b want=0", out_vld); end
      total++;
      if (in_rdy !== 1'b0) begin bad++; $display("FAIL reset_in_rdy got=%b want=0", in_rdy); end
      total++;
      if (occ !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occ); end
      total++;
      if (out_z !== 128'd0) begin bad++; $display("FAIL reset_out_z got=%h want=0", out_z); end
      #5;
      s_rst_n = 1'b1;
      tick();
      total++;
      if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_release_in_rdy got=%b want=1", in_rdy); end
   endtask

   task automatic test_single();
      logic [127:0] want_z;
      want_z = {32'd1, 32'd0, 32'd0, 32'd15};
      out_rdy = 1'b1;
      in_a = {16'd1, 16'd7, 16'hFFFF, 16'd3};
      in_b = {16'd1, 16'd0, 16'hFFFF, 16'd5};
      in_mask = 4'b1101;
      in_side = 8'hA5;
      in_vld = 1'b1;
      total++;
      if (in_rdy !== 1'b1) begin bad++; $display("FAIL single_in_rdy got=%b want=1", in_rdy); end
      tick();
      in_vld = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         total++;
         if (out_vld !== (k == 4)) begin
            bad++;
            $display("FAIL single_latency cycle=t+%0d got=%b want=%b", k, out_vld, (k == 4));
         end
         if (k < 4) tick();
      end
      total++;
      if (out_z !== want_z) begin bad++; $display("FAIL single_z got=%h want=%h", out_z, want_z); end
      total++;
      if (out_side !== 8'hA5) begin bad++; $display("FAIL single_side got=%h want=a5", out_side); end
      tick();
   endtask

   task automatic test_stream();
      int pops0;
      pops0 = pop_cnt;
      out_rdy = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_a = {$urandom, $urandom};
         in_b = {$urandom, $urandom};
         in_mask = 4'($urandom_range(0, 15));
         in_side = i[7:0];
         in_vld = 1'b1;
         total++;
         if (in_rdy !== 1'b1) begin bad++; $display("FAIL stream_in_rdy beat=%0d got=%b want=1", i, in_rdy); end
         tick();
      end
      in_vld = 1'b0;
      repeat (MULT_LAT + 1) tick();
      total++;
      if (pop_cnt - pops0 != 100) begin
         bad++;
         $display("FAIL stream_throughput got=%0d pops want=100", pop_cnt - pops0);
      end
      total++;
      if (occ !== 3'd0) begin bad++; $display("FAIL stream_drain_occ got=%0d want=0", occ); end
   endtask

   task automatic test_back_pressure();
      int acc;
      logic [135:0] held;
      logic held_v;
      acc = 0;
      held_v = 1'b0;
      held = '0;
      out_rdy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         in_a = {48'd0, 16'(i + 1)};
         in_b = {4{16'd2}};
         in_mask = 4'hF;
         in_side = 8'(8'h40 + i);
         in_vld = 1'b1;
         if (in_rdy) acc++;
         tick();
         if (out_vld) begin
            if (!held_v) begin
               held = {out_side, out_z};
               held_v = 1'b1;
            end else begin
               total++;
               if ({out_side, out_z} !== held) begin
                  bad++;
                  $display("FAIL bp_stable cycle=%0d got=%h want=%h", i, {out_side, out_z}, held);
               end
            end
         end
      end
      in_vld = 1'b0;
      total++;
      if (acc != DEPTH) begin bad++; $display("FAIL bp_accepts got=%0d want=%0d", acc, DEPTH); end
      total++;
      if (in_rdy !== 1'b0) begin bad++; $display("FAIL bp_in_rdy got=%b want=0", in_rdy); end
      total++;
      if (occ !== 3'd5) begin bad++; $display("FAIL bp_occ got=%0d want=5", occ); end
      total++;
      if (held !== {8'h40, 96'd0, 32'd2}) begin
         bad++;
         $display("FAIL bp_head got=%h want=%h", held, {8'h40, 96'd0, 32'd2});
      end
      out_rdy = 1'b1;
      repeat (DEPTH) tick();
      total++;
      if (occ !== 3'd0) begin bad++; $display("FAIL bp_release_occ got=%0d want=0", occ); end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL bp_leftover got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_random();
      logic [7:0] side_ctr;
      int pops0, acc;
      side_ctr = 8'd0;
      pops0 = pop_cnt;
      acc = 0;
      for (int i = 0; i < 300; i++) begin
         in_a = {$urandom, $urandom};
         in_b = {$urandom, $urandom};
         in_mask = 4'($urandom_range(0, 15));
         in_side = side_ctr;
         in_vld = 1'($urandom_range(0, 1));
         out_rdy = 1'($urandom_range(0, 1));
         if (in_vld && in_rdy) begin
            side_ctr++;
            acc++;
         end
         tick();
      end
      in_vld = 1'b0;
      out_rdy = 1'b1;
      for (int i = 0; i < 40 && occ !== 3'd0; i++) tick();
      total++;
      if (occ !== 3'd0) begin bad++; $display("FAIL random_drain got occ=%0d want=0", occ); end
      total++;
      if (pop_cnt - pops0 != acc) begin
         bad++;
         $display("FAIL random_count got=%0d pops want=%0d", pop_cnt - pops0, acc);
      end
   endtask

   task automatic test_reset_mid();
      out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_a = {4{16'(i + 9)}};
         in_b = {4{16'd3}};
         in_mask = 4'hF;
         in_side = 8'(i);
         in_vld = 1'b1;
         tick();
      end
      in_vld = 1'b0;
      repeat (5) tick();
      total++;
      if (occ !== 3'd4) begin bad++; $display("FAIL rmid_occ_before got=%0d want=4", occ); end
      total++;
      if (out_vld !== 1'b1) begin bad++; $display("FAIL rmid_vld_before got=%b want=1", out_vld); end
      #3;
      s_rst_n = 1'b0;
      #1;
      total++;
      if (out_vld !== 1'b0) begin bad++; $display("FAIL rmid_out_vld got=%b want=0", out_vld); end
      total++;
      if (in_rdy !== 1'b0) begin bad++; $display("FAIL rmid_in_rdy got=%b want=0", in_rdy); end
      total++;
      if (occ !== 3'd0) begin bad++; $display("FAIL rmid_occ got=%0d want=0", occ); end
      @(posedge clk);
      #2;
      s_rst_n = 1'b1;
      out_rdy = 1'b1;
      tick();
      total++;
      if (in_rdy !== 1'b1) begin bad++; $display("FAIL rmid_release_in_rdy got=%b want=1", in_rdy); end
      for (int i = 0; i < 10; i++) begin
         total++;
         if (out_vld !== 1'b0) begin bad++; $display("FAIL rmid_ghost cycle=%0d got=%b want=0", i, out_vld); end
         tick();
      end
   endtask

   task automatic test_signed();
      logic [127:0] want_z;
      int n;
`ifdef ARITH_MULT_PIPE_SIGNED_EN
      want_z = {32'hFFFF8001, 32'h00000001, 32'h40000000, 32'hFFFFFFFE};
`else
      want_z = {32'h7FFE8001, 32'hFFFE0001, 32'h40000000, 32'h0001FFFE};
`endif
      out_rdy = 1'b1;
      in_a = {16'h7FFF, 16'hFFFF, 16'h8000, 16'hFFFF};
      in_b = {16'hFFFF, 16'hFFFF, 16'h8000, 16'h0002};
      in_mask = 4'hF;
      in_side = 8'h77;
      in_vld = 1'b1;
      total++;
      if (in_rdy !== 1'b1) begin bad++; $display("FAIL sign_in_rdy got=%b want=1", in_rdy); end
      tick();
      in_vld = 1'b0;
      n = 0;
      while (out_vld !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      total++;
      if (out_vld !== 1'b1) begin
         bad++;
         $display("FAIL sign_timeout got out_vld=%b want=1", out_vld);
      end else begin
         total++;
         if (out_z !== want_z) begin bad++; $display("FAIL sign_z got=%h want=%h", out_z, want_z); end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_back_pressure();
      test_random();
      test_reset_mid();
      test_signed();
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
